// File: rtl/ysyx_23060203_redirect_ctrl.sv
// rtl/ysyx_23060203_redirect_ctrl.sv - pipeline flush/drain/redirect sequencer with boot redirect
// Optional REDIRECT_STATS_EN adds saturating event/cycle counters.
module ysyx_23060203_redirect_ctrl #(
  parameter int          PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h3000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_flush,
  input  logic [PC_W-1:0] wb_dnpc,
  input  logic            wb_fencei,
  input  logic            ex_redir,
  input  logic [PC_W-1:0] ex_dnpc,
  input  logic            ifu_busy,
  input  logic            lsu_busy,
  output logic            flush_all,
  output logic            flush_young,
  output logic            ifu_stall,
  output logic            icache_inval_req,
  input  logic            icache_inval_ack,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  input  logic            redir_ready,
`ifdef REDIRECT_STATS_EN
  output logic [CNT_W-1:0] stat_flush_cnt,
  output logic [CNT_W-1:0] stat_fencei_cnt,
  output logic [CNT_W-1:0] stat_branch_cnt,
  output logic [CNT_W-1:0] stat_drain_cyc,
`endif
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_INVAL = 3'd3,
    ST_REDIR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            fencei_q, fencei_d;

  logic in_idle;
  logic take_wb;
  logic take_ex;

  assign in_idle = (state_q == ST_IDLE);
  // wb_flush belongs to an older instruction, so it wins over a same-cycle ex_redir.
  assign take_wb = in_idle && wb_flush && !reset;
  assign take_ex = in_idle && ex_redir && !wb_flush && !reset;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fencei_d = fencei_q;
    case (state_q)
      ST_BOOT: begin
        if (redir_ready) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (take_wb) begin
          state_d  = ST_DRAIN;
          target_d = wb_dnpc;
          fencei_d = wb_fencei;
        end else if (take_ex) begin
          state_d  = ST_REDIR;
          target_d = ex_dnpc;
        end
      end
      ST_DRAIN: begin
        if (!ifu_busy && !lsu_busy) state_d = fencei_q ? ST_INVAL : ST_REDIR;
      end
      ST_INVAL: begin
        if (icache_inval_ack) state_d = ST_REDIR;
      end
      ST_REDIR: begin
        if (redir_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      target_q <= RESET_PC;
      fencei_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      fencei_q <= fencei_d;
    end
  end

  assign flush_all        = take_wb;
  assign flush_young      = take_ex;
  assign ifu_stall        = !in_idle;
  assign busy             = !in_idle;
  assign icache_inval_req = (state_q == ST_INVAL);
  assign redir_valid      = (state_q == ST_BOOT) || (state_q == ST_REDIR);
  assign redir_pc         = (state_q == ST_BOOT) ? {RESET_PC[PC_W-1:2], 2'b00}
                                                 : {target_q[PC_W-1:2], 2'b00};

`ifdef REDIRECT_STATS_EN
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fencei_cnt_q, fencei_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] drain_cyc_q, drain_cyc_d;
  logic             in_wait;

  assign in_wait = (state_q == ST_DRAIN) || (state_q == ST_INVAL);

  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    fencei_cnt_d = fencei_cnt_q;
    branch_cnt_d = branch_cnt_q;
    drain_cyc_d  = drain_cyc_q;
    if (take_wb && !(&flush_cnt_q))                fencei_cnt_d = fencei_cnt_q;
    if (take_wb && !(&flush_cnt_q))                flush_cnt_d  = flush_cnt_q + 1'b1;
    if (take_wb && wb_fencei && !(&fencei_cnt_q))  fencei_cnt_d = fencei_cnt_q + 1'b1;
    if (take_ex && !(&branch_cnt_q))               branch_cnt_d = branch_cnt_q + 1'b1;
    if (in_wait && !(&drain_cyc_q))                drain_cyc_d  = drain_cyc_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flush_cnt_q  <= '0;
      fencei_cnt_q <= '0;
      branch_cnt_q <= '0;
      drain_cyc_q  <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      fencei_cnt_q <= fencei_cnt_d;
      branch_cnt_q <= branch_cnt_d;
      drain_cyc_q  <= drain_cyc_d;
    end
  end

  assign stat_flush_cnt  = flush_cnt_q;
  assign stat_fencei_cnt = fencei_cnt_q;
  assign stat_branch_cnt = branch_cnt_q;
  assign stat_drain_cyc  = drain_cyc_q;
`endif

endmodule

// File: tb/tb_ysyx_23060203_redirect_ctrl.sv
// tb/tb_ysyx_23060203_redirect_ctrl.sv - directed-vector bench for ysyx_23060203_redirect_ctrl
module tb_ysyx_23060203_redirect_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_flush, wb_fencei, ex_redir;
  logic [31:0] wb_dnpc, ex_dnpc;
  logic        ifu_busy, lsu_busy;
  logic        flush_all, flush_young, ifu_stall;
  logic        icache_inval_req, icache_inval_ack;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic        busy;
`ifdef REDIRECT_STATS_EN
  logic [31:0] stat_flush_cnt, stat_fencei_cnt, stat_branch_cnt, stat_drain_cyc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ysyx_23060203_redirect_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .wb_flush         (wb_flush),
    .wb_dnpc          (wb_dnpc),
    .wb_fencei        (wb_fencei),
    .ex_redir         (ex_redir),
    .ex_dnpc          (ex_dnpc),
    .ifu_busy         (ifu_busy),
    .lsu_busy         (lsu_busy),
    .flush_all        (flush_all),
    .flush_young      (flush_young),
    .ifu_stall        (ifu_stall),
    .icache_inval_req (icache_inval_req),
    .icache_inval_ack (icache_inval_ack),
    .redir_valid      (redir_valid),
    .redir_pc         (redir_pc),
    .redir_ready      (redir_ready),
`ifdef REDIRECT_STATS_EN
    .stat_flush_cnt   (stat_flush_cnt),
    .stat_fencei_cnt  (stat_fencei_cnt),
    .stat_branch_cnt  (stat_branch_cnt),
    .stat_drain_cyc   (stat_drain_cyc),
`endif
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // A wb_flush driven while the controller is busy would be a bench protocol bug.
  always @(negedge clock) begin
    if (!reset && wb_flush && busy) chk("proto_wb_flush_busy", 32'd1, 32'd0);
  end

  initial begin
    reset = 1'b1; wb_flush = 0; wb_fencei = 0; ex_redir = 0;
    wb_dnpc = '0; ex_dnpc = '0; ifu_busy = 0; lsu_busy = 0;
    icache_inval_ack = 0; redir_ready = 0;
    tick(); tick();
    chk("rst_valid", redir_valid, 1);
    chk("rst_pc", redir_pc, 32'h3000_0000);
    chk("rst_stall", ifu_stall, 1);
    chk("rst_busy", busy, 1);
    chk("rst_flush_all", flush_all, 0);
    chk("rst_inval", icache_inval_req, 0);

    // 1: boot redirect held through two not-ready cycles
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) redir_ready = 1'b1;
      #0;
      chk("boot_valid", redir_valid, 1);
      chk("boot_pc", redir_pc, 32'h3000_0000);
      tick();
    end
    chk("boot_idle_stall", ifu_stall, 0);
    chk("boot_idle_busy", busy, 0);
    chk("boot_idle_valid", redir_valid, 0);

    // 2: plain wb_flush
    wb_flush = 1; wb_dnpc = 32'h8000_0104; #1;
    chk("t2_flush_all", flush_all, 1);
    chk("t2_flush_young", flush_young, 0);
    tick(); wb_flush = 0; #1;
    chk("t2_t1_flush_all", flush_all, 0);
    chk("t2_t1_valid", redir_valid, 0);
    chk("t2_t1_stall", ifu_stall, 1);
    tick();
    chk("t2_t2_valid", redir_valid, 1);
    chk("t2_t2_pc", redir_pc, 32'h8000_0104);
    tick();
    chk("t2_idle_stall", ifu_stall, 0);

    // 3: fence.i with lsu busy for 3 cycles and ack 4 cycles after req
    wb_flush = 1; wb_fencei = 1; wb_dnpc = 32'h8000_0200; lsu_busy = 1; #1;
    chk("t3_flush_all", flush_all, 1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      wb_flush = 0; wb_fencei = 0;
      lsu_busy = (c < 3);
      icache_inval_ack = (c == 7);
      #1;
      chk("t3_stall", ifu_stall, 1);
      chk("t3_inval_req", icache_inval_req, (c >= 4) ? 1 : 0);
      chk("t3_valid", redir_valid, 0);
    end
    tick(); icache_inval_ack = 0; #1;
    chk("t3_redir_valid", redir_valid, 1);
    chk("t3_inval_drop", icache_inval_req, 0);
    chk("t3_pc", redir_pc, 32'h8000_0200);
    tick();
    chk("t3_idle", busy, 0);

    // 4: same-cycle wb_flush and ex_redir
    wb_flush = 1; wb_dnpc = 32'h8000_0008; ex_redir = 1; ex_dnpc = 32'h8000_0020; #1;
    chk("t4_flush_all", flush_all, 1);
    chk("t4_flush_young", flush_young, 0);
    tick(); wb_flush = 0; ex_redir = 0;
    tick();
    chk("t4_valid", redir_valid, 1);
    chk("t4_pc", redir_pc, 32'h8000_0008);
    tick();
    chk("t4_idle", busy, 0);

    // 5: ex_redir with unaligned target and back-pressure; stale ex_redir ignored
    redir_ready = 0; ex_redir = 1; ex_dnpc = 32'h8000_0023; #1;
    chk("t5_flush_young", flush_young, 1);
    chk("t5_flush_all", flush_all, 0);
    tick(); ex_dnpc = 32'h9000_0000; #1;
    chk("t5_stale_young", flush_young, 0);
    chk("t5_v1", redir_valid, 1);
    chk("t5_pc1", redir_pc, 32'h8000_0020);
    tick(); ex_redir = 0; #1;
    chk("t5_v2", redir_valid, 1);
    chk("t5_pc2", redir_pc, 32'h8000_0020);
    tick(); redir_ready = 1; #1;
    chk("t5_v3", redir_valid, 1);
    chk("t5_pc3", redir_pc, 32'h8000_0020);
    tick();
    chk("t5_idle", busy, 0);
    chk("t5_idle_valid", redir_valid, 0);

    // 6: reset while in INVAL
    wb_flush = 1; wb_fencei = 1; wb_dnpc = 32'h8000_0400;
    tick(); wb_flush = 0; wb_fencei = 0;
    tick();
    chk("t6_inval", icache_inval_req, 1);
`ifdef REDIRECT_STATS_EN
    chk("t6_stat_flush", stat_flush_cnt, 4);
    chk("t6_stat_fencei", stat_fencei_cnt, 2);
    chk("t6_stat_branch", stat_branch_cnt, 1);
`endif
    reset = 1;
    tick();
    chk("t6_inval_off", icache_inval_req, 0);
    chk("t6_valid", redir_valid, 1);
    chk("t6_pc", redir_pc, 32'h3000_0000);
    chk("t6_busy", busy, 1);
`ifdef REDIRECT_STATS_EN
    chk("t6_stat_clr_flush", stat_flush_cnt, 0);
    chk("t6_stat_clr_drain", stat_drain_cyc, 0);
`endif
    reset = 0;
    tick();
    chk("t6_back_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
